// File: rtl/ib_mul_arb4.sv
// Four-requester round-robin front end sharing one 8x8 unsigned shift-add multiplier.
// Each accepted job produces one o_vld pulse carrying its product and requester index.
module ib_mul_arb4 (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic [3:0]  i_req,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [3:0]  o_gnt,
  output logic        o_busy,
  output logic        o_vld,
  output logic [1:0]  o_id,
  output logic [15:0] o_c
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  job_id_q, job_id_d;
  logic [1:0]  id_q, id_d;
  logic [7:0]  a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] c_q, c_d;

  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  cand;

  // Round-robin search: first active request at ptr, ptr+1, ptr+2, ptr+3 (wrapping).
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    job_id_d = job_id_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    c_d      = c_q;
    o_gnt    = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          o_gnt[win_idx] = 1'b1;
          a_d            = i_a[{win_idx, 3'b000} +: 8];
          b_d            = {8'h00, i_b[{win_idx, 3'b000} +: 8]};
          acc_d          = 16'h0000;
          job_id_d       = win_idx;
          ptr_d          = win_idx + 2'd1;
          state_d        = ST_RUN;
        end
      end
      ST_RUN: begin
        // Result register only moves when the accumulator is final.
        if (a_q == 8'h00) begin
          c_d     = acc_q;
          id_d    = job_id_q;
          state_d = ST_DONE;
        end else begin
          if (a_q[0]) begin
            acc_d = acc_q + b_q;
          end
          a_d = a_q >> 1;
          b_d = b_q << 1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'd0;
      job_id_q <= 2'd0;
      id_q     <= 2'd0;
      a_q      <= 8'h00;
      b_q      <= 16'h0000;
      acc_q    <= 16'h0000;
      c_q      <= 16'h0000;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      job_id_q <= job_id_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_vld  = (state_q == ST_DONE);
  assign o_id   = id_q;
  assign o_c    = c_q;

endmodule

// File: tb/tb_ib_mul_arb4.sv
// Self-checking bench for ib_mul_arb4: directed literal cases plus randomized traffic
// compared every cycle against a latency/queue-level behavioural model.
module tb_ib_mul_arb4;

  logic        i_clk  = 1'b0;
  logic        i_nrst = 1'b1;
  logic [3:0]  i_req  = 4'b0000;
  logic [31:0] i_a    = 32'h0;
  logic [31:0] i_b    = 32'h0;
  logic [3:0]  o_gnt;
  logic        o_busy;
  logic        o_vld;
  logic [1:0]  o_id;
  logic [15:0] o_c;

  ib_mul_arb4 dut (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_req  (i_req),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_gnt  (o_gnt),
    .o_busy (o_busy),
    .o_vld  (o_vld),
    .o_id   (o_id),
    .o_c    (o_c)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int msb_len(input logic [7:0] a);
    int m;
    m = 0;
    for (int i = 0; i < 8; i++) if (a[i]) m = i + 1;
    return m;
  endfunction

  function automatic int gidx(input logic [3:0] g);
    case (g)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  // Behavioural model: idle/busy, a completion cycle number, and the pending product.
  bit          m_busy = 0;
  int          m_cyc  = 0;
  int          m_done = 0;
  int          m_ptr  = 0;
  int          m_jid  = 0;
  int          m_oid  = 0;
  logic [15:0] m_prod = 16'h0;
  logic [15:0] m_c    = 16'h0;
  int          jobs_done = 0;
  logic [3:0]  eg;
  bit          ev;
  int          w;
  logic [7:0]  ga, gb;

  always @(negedge i_clk) begin
    m_cyc++;
    if (!i_nrst) begin
      m_busy = 0;
      m_ptr  = 0;
      m_c    = 16'h0;
      m_oid  = 0;
      chk("rst_gnt", 32'(o_gnt), 32'h0);
      chk("rst_busy", 32'(o_busy), 32'h0);
      chk("rst_vld", 32'(o_vld), 32'h0);
      chk("rst_id", 32'(o_id), 32'h0);
      chk("rst_c", 32'(o_c), 32'h0);
    end else begin
      eg = 4'b0000;
      ev = 0;
      w  = -1;
      if (!m_busy) begin
        for (int k = 0; k < 4; k++)
          if (w < 0 && i_req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        if (w >= 0) eg[w] = 1'b1;
      end else if (m_cyc == m_done) begin
        ev   = 1;
        m_c  = m_prod;
        m_oid = m_jid;
      end
      chk("gnt", 32'(o_gnt), 32'(eg));
      chk("busy", 32'(o_busy), 32'(m_busy));
      chk("vld", 32'(o_vld), 32'(ev));
      chk("c", 32'(o_c), 32'(m_c));
      chk("id", 32'(o_id), 32'(m_oid));
      if (w >= 0) begin
        ga     = i_a[8*w +: 8];
        gb     = i_b[8*w +: 8];
        m_busy = 1;
        m_done = m_cyc + 2 + msb_len(ga);
        m_ptr  = (w + 1) % 4;
        m_prod = 16'(ga) * 16'(gb);
        m_jid  = w;
      end else if (ev) begin
        m_busy = 0;
        jobs_done++;
      end
    end
  end

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_nrst = 1'b0;
    i_req  = 4'b0000;
    @(posedge i_clk); #1;
    i_nrst = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (o_busy && n < 20);
    chk("idle_timeout", 32'(o_busy), 32'h0);
  endtask

  task automatic single(input int n, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input logic [15:0] exp_c);
    int lat;
    bit seen;
    @(posedge i_clk); #1;
    i_a[8*n +: 8] = a;
    i_b[8*n +: 8] = b;
    i_req = 4'(1 << n);
    @(negedge i_clk);
    chk("single_gnt", 32'(o_gnt), 32'(1 << n));
    @(posedge i_clk); #1;
    i_req = 4'b0000;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 14) begin
      @(negedge i_clk);
      lat++;
      seen = o_vld;
    end
    chk("single_vld_seen", 32'(seen), 32'h1);
    chk("single_latency", 32'(lat), 32'(exp_lat));
    chk("single_c", 32'(o_c), 32'(exp_c));
    chk("single_id", 32'(o_id), 32'(n));
    $display("job id=%0d a=%02h b=%02h latency=%0d c=%04h", n, a, b, lat, o_c);
  endtask

  int          gseq [8];
  int          vid  [8];
  logic [15:0] vc   [8];
  int          ng, nv;

  task automatic collect_grants(input int want);
    int cyc;
    for (int i = 0; i < 8; i++) begin
      gseq[i] = -1;
      vid[i]  = -1;
      vc[i]   = 16'hxxxx;
    end
    ng  = 0;
    nv  = 0;
    cyc = 0;
    while (ng < want && cyc < 200) begin
      @(negedge i_clk);
      cyc++;
      if (o_gnt != 4'b0000) begin
        gseq[ng] = gidx(o_gnt);
        ng++;
      end
      if (o_vld && nv < 8) begin
        vc[nv]  = o_c;
        vid[nv] = int'(o_id);
        nv++;
      end
    end
    chk("grant_count", 32'(ng), 32'(want));
    @(posedge i_clk); #1;
    i_req = 4'b0000;
    wait_idle();
  endtask

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_order [5];
    int vcount, start, rc;
    bit pend [4];
    logic [3:0] g;

    #2 i_nrst = 1'b0;
    @(posedge i_clk); #1;
    i_nrst = 1'b1;

    // Single jobs with hand-computed products and latencies.
    single(0, 8'h0D, 8'h0B, 6, 16'h008F);
    single(1, 8'h00, 8'hFF, 2, 16'h0000);
    single(2, 8'hFF, 8'hFF, 10, 16'hFE01);
    single(3, 8'h07, 8'h00, 5, 16'h0000);

    // Contention: all four held, operands a=n+1, b=0x10.
    do_reset();
    @(posedge i_clk); #1;
    for (int n = 0; n < 4; n++) begin
      i_a[8*n +: 8] = 8'(n + 1);
      i_b[8*n +: 8] = 8'h10;
    end
    i_req = 4'b1111;
    collect_grants(5);
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) chk("contention_order", 32'(gseq[i]), 32'(exp_order[i]));
    for (int i = 0; i < 4; i++) begin
      chk("contention_c", 32'(vc[i]), 32'((i + 1) * 16));
      chk("contention_id", 32'(vid[i]), 32'(i));
      $display("contention result id=%0d c=%04h", vid[i], vc[i]);
    end

    // Fairness: after a grant to 2, requests 0 and 2 are served 0 then 2.
    do_reset();
    single(2, 8'h03, 8'h05, 4, 16'h000F);
    @(posedge i_clk); #1;
    i_a = 32'h0001_0001;
    i_b = 32'h0001_0001;
    i_req = 4'b0101;
    collect_grants(2);
    chk("fair_first", 32'(gseq[0]), 32'h0);
    chk("fair_second", 32'(gseq[1]), 32'h2);
    $display("fairness grants %0d then %0d", gseq[0], gseq[1]);

    // Reset in the middle of a long job.
    do_reset();
    @(posedge i_clk); #1;
    i_a[23:16] = 8'h80;
    i_b[23:16] = 8'h03;
    i_req = 4'b0100;
    @(negedge i_clk);
    chk("midrst_gnt", 32'(o_gnt), 32'h4);
    @(posedge i_clk); #1;
    i_req = 4'b0000;
    repeat (3) @(posedge i_clk);
    #1 i_nrst = 1'b0;
    @(negedge i_clk);
    chk("midrst_busy", 32'(o_busy), 32'h0);
    chk("midrst_c", 32'(o_c), 32'h0);
    @(posedge i_clk); #1;
    i_nrst = 1'b1;
    vcount = 0;
    repeat (14) begin
      @(negedge i_clk);
      if (o_vld) vcount++;
    end
    chk("midrst_no_vld", 32'(vcount), 32'h0);
    @(posedge i_clk); #1;
    i_a[15:8] = 8'h02;
    i_b[15:8] = 8'h03;
    i_req = 4'b1010;
    @(negedge i_clk);
    chk("midrst_regrant", 32'(o_gnt), 32'h2);
    $display("reset mid-run: abandoned job, regrant=%b", o_gnt);
    @(posedge i_clk); #1;
    i_req = 4'b0000;
    wait_idle();

    // Randomized traffic with holds, drops and fresh requests.
    for (int n = 0; n < 4; n++) pend[n] = 0;
    start = jobs_done;
    rc = 0;
    while ((jobs_done - start) < 3000 && rc < 60000) begin
      @(negedge i_clk);
      g = o_gnt;
      @(posedge i_clk); #1;
      rc++;
      for (int n = 0; n < 4; n++) begin
        if (g[n]) pend[n] = 0;
        else if (pend[n] && $urandom_range(0, 15) == 0) pend[n] = 0;
        if (!pend[n] && $urandom_range(0, 3) == 0) begin
          pend[n] = 1;
          i_a[8*n +: 8] = rnd_op();
          i_b[8*n +: 8] = rnd_op();
        end
        i_req[n] = pend[n];
      end
    end
    chk("random_jobs_done", 32'((jobs_done - start) >= 3000), 32'h1);
    $display("random phase: %0d jobs in %0d cycles", jobs_done - start, rc);
    i_req = 4'b0000;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
